// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: next-PC select encodings, fetch-stage
// state encoding and reset constants used by fetch and the control unit.
package cpu_pkg;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JAL  = 3'b010;
    localparam logic [2:0] NPC_JALR = 3'b100;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target selection and alignment check.
// Unknown npc_op encodings fall back to sequential PC+4.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = pc + 32'd4;
        case (npc_op)
            NPC_BR, NPC_JAL: target = pc + imm;
            NPC_JALR:        target = {alu_out[31:1], 1'b0};
            default:         target = pc + 32'd4;
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: handshakes with instruction
// memory, holds one instruction in execute, selects next PC, traps on misalignment.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        commit,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        misalign,
    output logic [31:0] instret
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instret_q, instret_d;
    logic         imem_req_q, imem_req_d;
    logic         instr_valid_q, instr_valid_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  target;
    logic         target_misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .npc_op     (npc_op),
        .imm        (imm),
        .alu_out    (alu_out),
        .target     (target),
        .misaligned (target_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // stall takes priority, so a misaligned target only traps once stall drops
                if (!stall) begin
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d      = target;
                        instret_d = instret_q + 32'd1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instret_q     <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instret_q     <= instret_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign commit      = instr_valid_q & ~stall & ~target_misaligned;
    assign pc          = pc_q;
    assign pc4         = pc_q + 32'd4;
    assign misalign    = misalign_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a scoreboard checks every fetch address
// and latched instruction, while each test task checks its own scenario.
module tb_pc_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  npc_op;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;
    logic [31:0] instret;
    logic [31:0] rdata_key;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] mon_exp;
    logic        prev_valid = 1'b0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .npc_op     (npc_op),
        .imm        (imm),
        .alu_out    (alu_out),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .commit     (commit),
        .pc         (pc),
        .pc4        (pc4),
        .misalign   (misalign),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // memory returns a word derived from the address so each fetch is distinguishable
    assign imem_rdata = imem_addr ^ rdata_key;

    always @(negedge clk) begin
        if (imem_req && imem_ack && !rst) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_fetch_unexpected addr=%h", imem_addr);
            end else begin
                mon_exp = exp_addr_q.pop_front();
                if (imem_addr !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_fetch_addr got=%h exp=%h", imem_addr, mon_exp);
                end
            end
        end
        if (instr_valid && !prev_valid && !rst) begin
            checks++;
            if (exp_instr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_instr_unexpected instr=%h", instr);
            end else begin
                mon_exp = exp_instr_q.pop_front();
                if (instr !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_instr got=%h exp=%h", instr, mon_exp);
                end
            end
        end
        prev_valid = instr_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        npc_op   = NPC_PC4;
        imm      = 32'd0;
        alu_out  = 32'd0;
        rdata_key = KEY;
        exp_addr_q.delete();
        exp_instr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int waits);
        exp_addr_q.push_back(addr);
        exp_instr_q.push_back(addr ^ rdata_key);
        imem_ack = 1'b0;
        repeat (waits) step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic drive_exec(input logic [2:0] op, input logic [31:0] imm_v,
                              input logic [31:0] alu_v);
        npc_op  = op;
        imm     = imm_v;
        alu_out = alu_v;
        stall   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; npc_op = NPC_PC4;
        imm = 32'd0; alu_out = 32'd0; rdata_key = KEY;
        #2;
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL rst_pc got=%h exp=0", pc); end
        checks++; if (instr !== NOP_INSTR) begin errors++; $display("[TB] FAIL rst_instr got=%h exp=%h", instr, NOP_INSTR); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign got=%b exp=0", misalign); end
        checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL rst_instret got=%h exp=0", instret); end
        checks++; if (pc4 !== 32'd4) begin errors++; $display("[TB] FAIL rst_pc4 got=%h exp=4", pc4); end
        checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL rst_commit got=%b exp=0", commit); end
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req got=%b exp=0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_back_to_back();
        int vcount = 0;
        int b2b = 0;
        logic pv = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_instr_q.push_back(32'(i * 4) ^ rdata_key);
        end
        imem_ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (instr_valid) begin
                vcount++;
                if (pv) b2b++;
            end
            pv = instr_valid;
        end
        imem_ack = 1'b0;
        checks++; if (vcount != 3) begin errors++; $display("[TB] FAIL seq_valid_count got=%0d exp=3", vcount); end
        checks++; if (b2b != 0) begin errors++; $display("[TB] FAIL seq_valid_width got=%0d exp=0", b2b); end
        checks++; if (instret !== 32'd3) begin errors++; $display("[TB] FAIL seq_instret got=%h exp=3", instret); end
        checks++; if (imem_addr !== 32'd12) begin errors++; $display("[TB] FAIL seq_next_addr got=%h exp=c", imem_addr); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("[TB] FAIL seq_leftover got=%0d exp=0", exp_addr_q.size()); end
    endtask

    task automatic test_branch();
        do_reset();
        step();
        do_fetch(32'h0, 0);
        drive_exec(NPC_JAL, 32'h100, 32'h0);
        checks++; if (commit !== 1'b1) begin errors++; $display("[TB] FAIL jal_commit got=%b exp=1", commit); end
        step();
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL jal_addr got=%h exp=100", imem_addr); end
        do_fetch(32'h100, 0);
        drive_exec(NPC_BR, 32'hFFFF_FFF0, 32'h0);
        checks++; if (pc4 !== 32'h104) begin errors++; $display("[TB] FAIL br_pc4 got=%h exp=104", pc4); end
        step();
        checks++; if (imem_addr !== 32'hF0) begin errors++; $display("[TB] FAIL br_addr got=%h exp=f0", imem_addr); end
        do_fetch(32'hF0, 0);
        drive_exec(NPC_JAL, 32'h10, 32'h0);
        step();
        do_fetch(32'h100, 0);
        drive_exec(NPC_PC4, 32'hFFFF_FFF0, 32'h0);
        step();
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL pc4_addr got=%h exp=104", imem_addr); end
        do_fetch(32'h104, 0);
        drive_exec(3'b111, 32'h40, 32'h40);
        step();
        checks++; if (imem_addr !== 32'h108) begin errors++; $display("[TB] FAIL badop_addr got=%h exp=108", imem_addr); end
        do_fetch(32'h108, 0);
        drive_exec(NPC_JALR, 32'h0, 32'h2001);
        checks++; if (commit !== 1'b1) begin errors++; $display("[TB] FAIL jalr_commit got=%b exp=1", commit); end
        step();
        checks++; if (imem_addr !== 32'h2000) begin errors++; $display("[TB] FAIL jalr_addr got=%h exp=2000", imem_addr); end
        checks++; if (instret !== 32'd6) begin errors++; $display("[TB] FAIL br_instret got=%h exp=6", instret); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("[TB] FAIL br_leftover got=%0d exp=0", exp_addr_q.size()); end
    endtask

    task automatic test_misalign();
        int bad = 0;
        do_reset();
        step();
        do_fetch(32'h0, 0);
        drive_exec(NPC_JALR, 32'h0, 32'h2003);
        checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL trap_commit got=%b exp=0", commit); end
        step();
        checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL trap_flag got=%b exp=1", misalign); end
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL trap_pc got=%h exp=0", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_valid got=%b exp=0", instr_valid); end
        checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL trap_instret got=%h exp=0", instret); end
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req !== 1'b0 || misalign !== 1'b1 || commit !== 1'b0) bad++;
        end
        imem_ack = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL halt_hold got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_delayed_ack();
        int bad = 0;
        do_reset();
        step();
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back(32'h0 ^ rdata_key);
        for (int i = 0; i < 3; i++) begin
            step();
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wait_req_hold got=%0d bad cycles exp=0", bad); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_valid got=%b exp=1", instr_valid); end
        rdata_key = 32'h0BAD_0000;
        imem_ack  = 1'b1;
        stall     = 1'b1;
        step();
        imem_ack  = 1'b0;
        rdata_key = KEY;
        checks++; if (instr !== (32'h0 ^ KEY)) begin errors++; $display("[TB] FAIL stray_ack_instr got=%h exp=%h", instr, 32'h0 ^ KEY); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stray_ack_valid got=%b exp=1", instr_valid); end
        drive_exec(NPC_PC4, 32'h0, 32'h0);
        step();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL wait_next_addr got=%h exp=4", imem_addr); end
        checks++; if (instret !== 32'd1) begin errors++; $display("[TB] FAIL wait_instret got=%h exp=1", instret); end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        step();
        do_fetch(32'h0, 0);
        npc_op = NPC_BR;
        imm    = 32'h2;
        stall  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (commit !== 1'b0) bad++;
            step();
            if (pc !== 32'h0 || instr !== (32'h0 ^ KEY) || instret !== 32'd0 ||
                instr_valid !== 1'b1 || misalign !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stall_freeze got=%0d bad samples exp=0", bad); end
        drive_exec(NPC_PC4, 32'h0, 32'h0);
        checks++; if (commit !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_commit got=%b exp=1", commit); end
        step();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stall_release_addr got=%h exp=4", imem_addr); end
        checks++; if (instret !== 32'd1) begin errors++; $display("[TB] FAIL stall_release_instret got=%h exp=1", instret); end
        do_fetch(32'h4, 0);
        npc_op = NPC_BR;
        imm    = 32'h2;
        stall  = 1'b1;
        step();
        step();
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL stall_blocks_trap got=%b exp=0", misalign); end
        drive_exec(NPC_BR, 32'h2, 32'h0);
        checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL late_trap_commit got=%b exp=0", commit); end
        step();
        checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL late_trap_flag got=%b exp=1", misalign); end
        checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL late_trap_pc got=%h exp=4", pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        do_fetch(32'h0, 0);
        drive_exec(NPC_JAL, 32'hFFFF_FFFC, 32'h0);
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top_addr got=%h exp=fffffffc", imem_addr); end
        do_fetch(32'hFFFF_FFFC, 0);
        checks++; if (pc4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got=%h exp=0", pc4); end
        drive_exec(NPC_PC4, 32'h0, 32'h0);
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr got=%h exp=0", imem_addr); end
        checks++; if (instret !== 32'd2) begin errors++; $display("[TB] FAIL wrap_instret got=%h exp=2", instret); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        step();
        do_fetch(32'h0, 0);
        drive_exec(NPC_PC4, 32'h0, 32'h0);
        step();
        imem_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL arst_pc got=%h exp=0", pc); end
        checks++; if (instr !== NOP_INSTR) begin errors++; $display("[TB] FAIL arst_instr got=%h exp=%h", instr, NOP_INSTR); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL arst_req got=%b exp=0", imem_req); end
        checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL arst_instret got=%h exp=0", instret); end
        checks++; if (instr_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("[TB] FAIL arst_flags got=%b%b exp=00", instr_valid, misalign); end
        @(posedge clk); #1;
        imem_ack = 1'b0;
        rst      = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL arst_idle_req got=%b exp=0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL arst_refetch got=%b/%h exp=1/0", imem_req, imem_addr); end
        checks++; if (exp_addr_q.size() != 0 || exp_instr_q.size() != 0) begin errors++; $display("[TB] FAIL arst_leftover got=%0d exp=0", exp_addr_q.size() + exp_instr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch();
        test_misalign();
        test_delayed_ack();
        test_stall();
        test_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
